// File: rtl/iq_pair_fifo.sv
// Re-pairs the decimator's TDM Q/I word stream into {I,Q} words and buffers them in a RAM FIFO.
// Build option: IQ_PAIR_FIFO_AFULL_EN adds a registered almost_full output (level >= afull).
//
// state | meaning
// S_Q   | waiting for the Q word of the next pair
// S_I   | Q word held, the I word must arrive on this cycle
module iq_pair_fifo #(
    parameter int dsz   = 16,
    parameter int asz   = 8,
    parameter int afull = 192
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               valid,
    input  logic [dsz-1:0]     qi_in,
    input  logic               rd_en,
    output logic [2*dsz-1:0]   rd_data,
    output logic               rd_valid,
    output logic               empty,
    output logic               full,
    output logic [asz:0]       level,
    output logic [7:0]         ovf_cnt,
    output logic               sync_err,
    input  logic               err_clr
`ifdef IQ_PAIR_FIFO_AFULL_EN
    ,
    output logic               almost_full
`endif
);

    typedef enum logic {
        S_Q = 1'b0,
        S_I = 1'b1
    } state_t;

    localparam int depth = 1 << asz;
    localparam logic [asz:0] depth_lv = {1'b1, {asz{1'b0}}};
    localparam logic [asz:0] ptr_one  = {{asz{1'b0}}, 1'b1};

    // Elaboration-time guard: a threshold outside 1..depth could never behave sensibly.
    if (afull < 1 || afull > depth) begin : g_afull_range
        $error("iq_pair_fifo: afull must lie in 1..2**asz");
    end

    state_t state_q;
    state_t state_d;

    logic               q_load;
    logic               wr_req;
    logic               sync_evt;
    logic [dsz-1:0]     q_hold;
    logic [2*dsz-1:0]   wr_word;

    logic [asz:0]       wr_ptr;
    logic [asz:0]       rd_ptr;
    logic [asz:0]       wr_ptr_d;
    logic [asz:0]       rd_ptr_d;
    logic [asz:0]       level_d;
    logic               wr_acc;
    logic               rd_acc;
    logic               drop;

    logic [2*dsz-1:0]   mem [depth];

    // Pairing FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_Q;
        end else begin
            state_q <= state_d;
        end
    end

    // Pairing FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_Q: begin
                if (valid) begin
                    state_d = S_I;
                end
            end
            S_I: begin
                state_d = S_Q;
            end
            default: begin
                state_d = S_Q;
            end
        endcase
    end

    // Pairing FSM: outputs. A missing I strobe simply abandons the held Q word.
    always_comb begin
        q_load   = 1'b0;
        wr_req   = 1'b0;
        sync_evt = 1'b0;
        case (state_q)
            S_Q: begin
                q_load = valid;
            end
            S_I: begin
                wr_req   = valid;
                sync_evt = ~valid;
            end
            default: begin
                q_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_hold <= '0;
        end else if (q_load) begin
            q_hold <= qi_in;
        end
    end

    assign wr_word = {qi_in, q_hold};

    // Full/empty are the registered flags, so a write at full is dropped even if a read frees a slot.
    assign wr_acc   = wr_req & ~full;
    assign drop     = wr_req & full;
    assign rd_acc   = rd_en & ~empty;

    assign wr_ptr_d = wr_acc ? (wr_ptr + ptr_one) : wr_ptr;
    assign rd_ptr_d = rd_acc ? (rd_ptr + ptr_one) : rd_ptr;
    assign level_d  = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            level  <= level_d;
            empty  <= (level_d == '0);
            full   <= (level_d == depth_lv);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[asz-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr[asz-1:0]];
            end
        end
    end

    // A new error in the clearing cycle takes precedence over err_clr.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_cnt <= '0;
        end else if (err_clr) begin
            ovf_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_err <= 1'b0;
        end else if (sync_evt) begin
            sync_err <= 1'b1;
        end else if (err_clr) begin
            sync_err <= 1'b0;
        end
    end

`ifdef IQ_PAIR_FIFO_AFULL_EN
    localparam logic [asz:0] afull_lv = (asz + 1)'(afull);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (level_d >= afull_lv);
        end
    end
`endif

endmodule

// File: tb/tb_iq_pair_fifo.sv
// Directed scoreboard bench for iq_pair_fifo; almost_full checks run only with IQ_PAIR_FIFO_AFULL_EN.
module tb_iq_pair_fifo;

    localparam int dsz = 16;
    localparam int asz = 8;
    localparam int depth = 256;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              valid = 1'b0;
    logic [dsz-1:0]    qi_in = '0;
    logic              rd_en = 1'b0;
    logic              err_clr = 1'b0;
    logic [2*dsz-1:0]  rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [asz:0]      level;
    logic [7:0]        ovf_cnt;
    logic              sync_err;
`ifdef IQ_PAIR_FIFO_AFULL_EN
    logic              almost_full;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] sb[$];
    int          mlev = 0;
    int          movf = 0;

    iq_pair_fifo #(.dsz(dsz), .asz(asz), .afull(192)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid    (valid),
        .qi_in    (qi_in),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .ovf_cnt  (ovf_cnt),
        .sync_err (sync_err),
        .err_clr  (err_clr)
`ifdef IQ_PAIR_FIFO_AFULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [15:0] q, input logic [15:0] i);
        if (mlev == depth) begin
            if (movf < 255) movf++;
        end else begin
            sb.push_back({i, q});
            mlev++;
        end
    endtask

    task automatic send_pair(input logic [15:0] q, input logic [15:0] i);
        valid = 1'b1;
        qi_in = q;
        tick();
        qi_in = i;
        tick();
        valid = 1'b0;
        model_write(q, i);
    endtask

    task automatic read_one(input string tag);
        logic        ok;
        logic [31:0] exp;
        ok  = (mlev > 0);
        exp = '0;
        if (ok) begin
            exp = sb.pop_front();
            mlev--;
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_rd_valid"}, rd_valid, ok);
        if (ok) chk({tag, "_rd_data"}, rd_data, exp);
    endtask

    task automatic model_reset();
        sb.delete();
        mlev = 0;
        movf = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_ovf"}, ovf_cnt, 0);
        chk({tag, "_sync"}, sync_err, 0);
`ifdef IQ_PAIR_FIFO_AFULL_EN
        chk({tag, "_afull"}, almost_full, 0);
`endif
    endtask

    initial begin
        logic [31:0] exp;
        logic [31:0] last;
        // reset
        reset_n = 1'b0;
        tick();
        tick();
        chk_reset_state("rst");
        reset_n = 1'b1;
        tick();

        // basic pair, one-cycle write and read latency
        send_pair(16'h1234, 16'hABCD);
        chk("t1_empty", empty, 0);
        chk("t1_level", level, 1);
        read_one("t1");
        chk("t1_level0", level, 0);
        chk("t1_empty1", empty, 1);
        tick();
        chk("t1_rdv_pulse", rd_valid, 0);
        chk("t1_hold", rd_data, 32'hABCD1234);
        read_one("t1_empty_rd");
        chk("t1_empty_lvl", level, 0);

        // framing error: gap between Q and I
        valid = 1'b1;
        qi_in = 16'h0001;
        tick();
        valid = 1'b0;
        tick();
        chk("t2_sync", sync_err, 1);
        chk("t2_lvl0", level, 0);
        send_pair(16'h0002, 16'h0003);
        chk("t2_lvl1", level, 1);
        read_one("t2");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t2_clr", sync_err, 0);

        // sync error in the err_clr cycle wins
        valid = 1'b1;
        qi_in = 16'h0005;
        tick();
        valid = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t2_clr_wins", sync_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t2_clr2", sync_err, 0);

        // fill past full
        for (int k = 0; k < 258; k++) begin
            send_pair(16'(k), 16'(k) ^ 16'h5A5A);
            if (k == 254) chk("t3_not_full", full, 0);
        end
        chk("t3_full", full, 1);
        chk("t3_level", level, 9'd256);
        chk("t3_ovf", ovf_cnt, movf);
        chk("t3_ovf2", ovf_cnt, 2);

        // I strobe at full coincides with a read: pair dropped, read proceeds
        valid = 1'b1;
        qi_in = 16'hDEAD;
        tick();
        qi_in = 16'hBEEF;
        rd_en = 1'b1;
        exp = sb.pop_front();
        mlev--;
        if (movf < 255) movf++;
        tick();
        valid = 1'b0;
        rd_en = 1'b0;
        chk("t4_rdv", rd_valid, 1);
        chk("t4_data", rd_data, exp);
        chk("t4_level", level, 9'd255);
        chk("t4_ovf", ovf_cnt, 3);
        chk("t4_full", full, 0);

        // drain remaining pairs in order
        for (int k = 0; k < 255; k++) read_one("t3_drain");
        chk("t3_drained", empty, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_ovf_clr", ovf_cnt, 0);
        movf = 0;

        // streaming with pointer wrap
        for (int k = 0; k < 1000; k++) begin
            valid = 1'b1;
            qi_in = 16'(k * 3);
            rd_en = (mlev > 0);
            exp = '0;
            if (rd_en) begin
                exp = sb.pop_front();
                mlev--;
            end
            tick();
            if (rd_en) begin
                if (rd_valid !== 1'b1 || rd_data !== exp) chk("t5_data", {rd_valid, rd_data}, {1'b1, exp});
            end
            rd_en = 1'b0;
            qi_in = 16'(k * 3) ^ 16'hF00F;
            tick();
            model_write(16'(k * 3), 16'(k * 3) ^ 16'hF00F);
            if (level !== 9'(mlev) || level > 2) chk("t5_level", level, mlev);
        end
        valid = 1'b0;
        checks++;
        read_one("t5_last");
        chk("t5_ovf", ovf_cnt, 0);
        chk("t5_empty", empty, 1);

`ifdef IQ_PAIR_FIFO_AFULL_EN
        for (int k = 0; k < 191; k++) send_pair(16'(k), 16'(k + 1));
        chk("af_191", almost_full, 0);
        send_pair(16'h0BAD, 16'hCAFE);
        chk("af_192", almost_full, 1);
        read_one("af_rd");
        chk("af_after_rd", almost_full, 0);
`endif

        // reset while in S_I with data buffered
        send_pair(16'h1111, 16'h2222);
        valid = 1'b1;
        qi_in = 16'h3333;
        tick();
        valid = 1'b0;
        reset_n = 1'b0;
        tick();
        model_reset();
        chk_reset_state("midrst");
        reset_n = 1'b1;
        tick();
        send_pair(16'h4444, 16'h5555);
        chk("midrst_lvl", level, 1);
        read_one("midrst");
        chk("midrst_sync", sync_err, 0);
        last = rd_data;
        chk("midrst_word", last, 32'h55554444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
